// File: rtl/jtframe_pocket_upload_if.sv
// Bridge read / ioctl byte-read bundle for the Pocket upload path.
// The master side drives requests and core bytes; the slave serves reads.
interface jtframe_pocket_upload_if #(
    parameter int AW = 25
);
    logic          bridge_rd;
    logic [31:0]   bridge_addr;
    logic [31:0]   bridge_rd_data;
    logic          rd_valid;
    logic          busy;
    logic          ovf;
    logic          ds_done;
    logic          uploading;
    logic [AW-1:0] ioctl_addr;
    logic          ioctl_rd;
    logic          ioctl_ram;
    logic [7:0]    ioctl_din;

    modport master (
        output bridge_rd, bridge_addr, ds_done, ioctl_din,
        input  bridge_rd_data, rd_valid, busy, ovf,
        input  uploading, ioctl_addr, ioctl_rd, ioctl_ram
    );

    modport slave (
        input  bridge_rd, bridge_addr, ds_done, ioctl_din,
        output bridge_rd_data, rd_valid, busy, ovf,
        output uploading, ioctl_addr, ioctl_rd, ioctl_ram
    );
endinterface

// File: rtl/jtframe_pocket_upload.sv
// Serves APF bridge word reads by fetching four ioctl bytes from the core.
// One pending request is buffered; further reads during a fetch set ovf.
module jtframe_pocket_upload #(
    parameter int           AW       = 25,
    parameter int           RDLAT    = 2,
    parameter logic [7:0]   CMD_PAGE = 8'hF8
)(
    input  logic                      clk,
    input  logic                      rst_n,
    jtframe_pocket_upload_if.slave    bus
);
    localparam int CW = (RDLAT < 2) ? 1 : $clog2(RDLAT + 1);
    localparam logic [CW-1:0] RL = CW'(RDLAT);

    typedef enum logic { IDLE = 1'b0, FETCH = 1'b1 } st_t;

    st_t           st, st_nx;
    logic [1:0]    k, k_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] addr, addr_nx;
    logic          rd, rd_nx;
    logic [31:0]   word, word_nx;
    logic [31:0]   data, data_nx;
    logic          vld, vld_nx;
    logic          pv, pv_nx;
    logic [AW-1:0] pb, pb_nx;
    logic          ovf, ovf_nx;
    logic          up, up_nx;
    logic          busy, busy_nx;

    logic          accept, done, start;
    logic [AW-1:0] base, start_addr;
    logic [AW+24:0] base_w;
    logic          unused;

    assign accept = bus.bridge_rd &&
                    (bus.bridge_addr[31:24] != CMD_PAGE);
    assign base_w = {{AW{1'b0}}, bus.bridge_addr[22:0], 2'b00};
    assign base   = base_w[AW-1:0];
    assign unused = ^{bus.bridge_addr[23], base_w[AW+24:AW]};

    always_comb begin
        st_nx      = st;
        k_nx       = k;
        cnt_nx     = cnt;
        addr_nx    = addr;
        rd_nx      = 1'b0;
        word_nx    = word;
        data_nx    = data;
        vld_nx     = 1'b0;
        pv_nx      = pv;
        pb_nx      = pb;
        ovf_nx     = ovf;
        done       = 1'b0;
        start      = 1'b0;
        start_addr = base;

        if (accept)           up_nx = 1'b1;
        else if (bus.ds_done) up_nx = 1'b0;
        else                  up_nx = up;

        unique case (st)
            IDLE: begin
                start = accept;
            end
            FETCH: begin
                if (cnt != RL) begin
                    cnt_nx = cnt + CW'(1);
                end else begin
                    cnt_nx = '0;
                    word_nx[{k, 3'b000} +: 8] = bus.ioctl_din;
                    if (k != 2'd3) begin
                        k_nx          = k + 2'd1;
                        addr_nx[1:0]  = addr[1:0] + 2'd1;
                        rd_nx         = 1'b1;
                    end else begin
                        done    = 1'b1;
                        data_nx = {bus.ioctl_din, word[23:0]};
                        vld_nx  = 1'b1;
                    end
                end
                // Completion frees the pending slot in the same cycle
                if (done) begin
                    if (pv) begin
                        start      = 1'b1;
                        start_addr = pb;
                        pv_nx      = accept;
                        if (accept) pb_nx = base;
                    end else if (accept) begin
                        start = 1'b1;
                    end else begin
                        st_nx = IDLE;
                    end
                end else if (accept) begin
                    if (pv) begin
                        ovf_nx = 1'b1;
                    end else begin
                        pv_nx = 1'b1;
                        pb_nx = base;
                    end
                end
            end
            default: st_nx = IDLE;
        endcase

        if (start) begin
            st_nx   = FETCH;
            addr_nx = start_addr;
            rd_nx   = 1'b1;
            k_nx    = 2'd0;
            cnt_nx  = '0;
        end

        busy_nx = (st_nx != IDLE) | pv_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= IDLE;
            k    <= 2'd0;
            cnt  <= '0;
            addr <= '0;
            rd   <= 1'b0;
            word <= '0;
            data <= '0;
            vld  <= 1'b0;
            pv   <= 1'b0;
            pb   <= '0;
            ovf  <= 1'b0;
            up   <= 1'b0;
            busy <= 1'b0;
        end else begin
            st   <= st_nx;
            k    <= k_nx;
            cnt  <= cnt_nx;
            addr <= addr_nx;
            rd   <= rd_nx;
            word <= word_nx;
            data <= data_nx;
            vld  <= vld_nx;
            pv   <= pv_nx;
            pb   <= pb_nx;
            ovf  <= ovf_nx;
            up   <= up_nx;
            busy <= busy_nx;
        end
    end

    assign bus.bridge_rd_data = data;
    assign bus.rd_valid       = vld;
    assign bus.busy           = busy;
    assign bus.ovf            = ovf;
    assign bus.uploading      = up;
    assign bus.ioctl_ram      = up;
    assign bus.ioctl_addr     = addr;
    assign bus.ioctl_rd       = rd;
endmodule
